// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for a gray-pointer asynchronous FIFO.
// Everything here runs in the read clock domain; wptr_gray_sync arrives already synchronised.
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  clr_err,
    input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ram_re,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          pop;

    // Pop handshake: rd_en is a request, accepted only while the registered
    // empty is low; ram_re marks the accepted pop and rd_valid qualifies the
    // RAM data one clock later. A request while empty is refused and flagged.
    assign pop        = rd_en & ~empty;
    assign ram_re     = pop;
    assign raddr      = rbin[ADDR_WIDTH-1:0];
    assign rbin_next  = rbin + PW'(pop);
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    assign level_next = wbin - rbin_next;

    // Gray to binary: bit i is the XOR of all gray bits at or above i.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(wptr_gray_sync >> i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin         <= '0;
            rptr_gray    <= '0;
            rd_valid     <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rptr_gray    <= rgray_next;
            rd_valid     <= pop;
            // Full gray compare including MSB keeps a wrapped-full FIFO distinct from empty.
            empty        <= (rgray_next == wptr_gray_sync);
            rd_level     <= level_next;
            almost_empty <= (level_next <= AE_LEVEL);
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: per-cycle expected observations queued by the driver,
// popped and compared by an independent negedge monitor.
module tb_fifo_rd_ctrl;

    typedef struct packed {
        logic       re;
        logic [3:0] raddr;
        logic       rdv;
        logic       empty;
        logic       ae;
        logic [4:0] level;
        logic       uf;
        logic [4:0] rgray;
    } exp_t;

    localparam int W = $bits(exp_t);

    logic       clk;
    logic       rst;
    logic       rd_en;
    logic       clr_err;
    logic [4:0] wptr_gray_sync;
    logic [4:0] rptr_gray;
    logic [3:0] raddr;
    logic       ram_re;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic       underflow;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // expected registered state before the next edge
    logic       cur_empty, cur_ae, cur_uf, prev_re;
    logic [4:0] cur_lvl, cur_rg;

    fifo_rd_ctrl #(.ADDR_WIDTH(4), .ALMOST_EMPTY(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_en          (rd_en),
        .clr_err        (clr_err),
        .wptr_gray_sync (wptr_gray_sync),
        .rptr_gray      (rptr_gray),
        .raddr          (raddr),
        .ram_re         (ram_re),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .rd_level       (rd_level),
        .underflow      (underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] g(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        cur_empty = 1'b1;
        cur_ae    = 1'b1;
        cur_uf    = 1'b0;
        cur_lvl   = 5'd0;
        cur_rg    = 5'd0;
        prev_re   = 1'b0;
    endtask

    // driver: one clock of stimulus; n_* are the expected registered values after this edge
    task automatic step(input logic rd, input logic cl, input logic [4:0] w,
                        input logic e_re, input logic [3:0] e_ra,
                        input logic [4:0] n_lvl, input logic n_empty, input logic n_ae,
                        input logic n_uf, input logic [4:0] n_rg);
        exp_t e;
        @(posedge clk);
        #1;
        rd_en          = rd;
        clr_err        = cl;
        wptr_gray_sync = w;
        e.re    = e_re;
        e.raddr = e_ra;
        e.rdv   = prev_re;
        e.empty = cur_empty;
        e.ae    = cur_ae;
        e.level = cur_lvl;
        e.uf    = cur_uf;
        e.rgray = cur_rg;
        exp_q.push_back(W'(e));
        prev_re   = e_re;
        cur_lvl   = n_lvl;
        cur_empty = n_empty;
        cur_ae    = n_ae;
        cur_uf    = n_uf;
        cur_rg    = n_rg;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        rd_en          = 1'b0;
        clr_err        = 1'b0;
        wptr_gray_sync = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_t'(exp_q.pop_front());
            chk("ram_re",       8'(ram_re),       8'(e.re));
            chk("raddr",        8'(raddr),        8'(e.raddr));
            chk("rd_valid",     8'(rd_valid),     8'(e.rdv));
            chk("empty",        8'(empty),        8'(e.empty));
            chk("almost_empty", 8'(almost_empty), 8'(e.ae));
            chk("rd_level",     8'(rd_level),     8'(e.level));
            chk("underflow",    8'(underflow),    8'(e.uf));
            chk("rptr_gray",    8'(rptr_gray),    8'(e.rgray));
        end
    end

    initial begin
        rst            = 1'b1;
        rd_en          = 1'b0;
        clr_err        = 1'b0;
        wptr_gray_sync = 5'd0;
        model_reset();
        @(negedge clk);
        chk("rst_empty",     8'(empty),        8'd1);
        chk("rst_ae",        8'(almost_empty), 8'd1);
        chk("rst_level",     8'(rd_level),     8'd0);
        chk("rst_rgray",     8'(rptr_gray),    8'd0);
        chk("rst_raddr",     8'(raddr),        8'd0);
        chk("rst_ram_re",    8'(ram_re),       8'd0);
        chk("rst_rd_valid",  8'(rd_valid),     8'd0);
        chk("rst_underflow", 8'(underflow),    8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // mid-stream reset: 8 written, 5 popped, then async reset
        step(0, 0, 5'b01100, 0, 4'd0, 5'd8, 0, 0, 0, 5'd0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 5'b01100, 1, 4'(i), 5'(7 - i), 0, 0, 0, g(i + 1));
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("pre_rst_rd_valid", 8'(rd_valid),  8'd1);
        chk("pre_rst_level",    8'(rd_level),  8'd3);
        chk("pre_rst_rgray",    8'(rptr_gray), 8'b00111);
        wptr_gray_sync = 5'd0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_empty",    8'(empty),     8'd1);
        chk("mid_rst_level",    8'(rd_level),  8'd0);
        chk("mid_rst_rgray",    8'(rptr_gray), 8'd0);
        chk("mid_rst_rd_valid", 8'(rd_valid),  8'd0);
        chk("mid_rst_uf",       8'(underflow), 8'd0);
        chk("mid_rst_raddr",    8'(raddr),     8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // fill 3 then drain
        step(0, 0, 5'b00010, 0, 4'd0, 5'd3, 0, 0, 0, 5'd0);
        step(1, 0, 5'b00010, 1, 4'd0, 5'd2, 0, 1, 0, 5'b00001);
        step(1, 0, 5'b00010, 1, 4'd1, 5'd1, 0, 1, 0, 5'b00011);
        step(1, 0, 5'b00010, 1, 4'd2, 5'd0, 1, 1, 0, 5'b00010);
        step(0, 0, 5'b00010, 0, 4'd3, 5'd0, 1, 1, 0, 5'b00010);

        // underflow: sticky, clear, set wins over clear
        step(1, 0, 5'b00010, 0, 4'd3, 5'd0, 1, 1, 1, 5'b00010);
        step(0, 0, 5'b00010, 0, 4'd3, 5'd0, 1, 1, 1, 5'b00010);
        step(0, 1, 5'b00010, 0, 4'd3, 5'd0, 1, 1, 0, 5'b00010);
        step(1, 1, 5'b00010, 0, 4'd3, 5'd0, 1, 1, 1, 5'b00010);
        step(0, 1, 5'b00010, 0, 4'd3, 5'd0, 1, 1, 0, 5'b00010);

        // full and wrap
        do_reset();
        step(0, 0, 5'b11000, 0, 4'd0, 5'd16, 0, 0, 0, 5'd0);
        for (int i = 0; i < 16; i++)
            step(1, 0, 5'b11000, 1, 4'(i), 5'(15 - i), (i == 15), ((15 - i) <= 2), 0, g(i + 1));
        step(0, 0, 5'b11001, 0, 4'd0, 5'd1, 0, 1, 0, 5'b11000);
        step(1, 0, 5'b11001, 1, 4'd0, 5'd0, 1, 1, 0, 5'b11001);

        // simultaneous write advance and pop: level holds at 2
        step(0, 0, 5'b11010, 0, 4'd1, 5'd2, 0, 1, 0, 5'b11001);
        step(1, 0, 5'b11110, 1, 4'd1, 5'd2, 0, 1, 0, 5'b11011);
        step(0, 0, 5'b11110, 0, 4'd2, 5'd2, 0, 1, 0, 5'b11011);

        // gray decode sweep, no pops
        do_reset();
        for (int i = 0; i < 32; i++)
            step(0, 0, g(i), 0, 4'd0, 5'(i), (i == 0), (i <= 2), 0, 5'd0);
        step(0, 0, 5'd0, 0, 4'd0, 5'd0, 1, 1, 0, 5'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
